// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, memory-port owner and arbiter state encodings.
package cpu_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MEM stage, with DM priority
// and a starvation guard that forces an IF grant after STARVE_MAX back-to-back DM grants.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam int STV_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

   arb_state_e        state_q,   state_d;
   owner_e            owner_q,   owner_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;
   logic              we_q,      we_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [STV_W-1:0]  starve_q,  starve_d;
   logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
   logic [DATA_W-1:0] dmRdata_q, dmRdata_d;
   logic              ifAck_q,   ifAck_d;
   logic              dmAck_q,   dmAck_d;
   logic              grantIf;
   logic              inAccess;

   // IF wins only when DM is idle or IF has waited through STARVE_MAX DM grants.
   assign grantIf = if_req & (~dm_req | (starve_q == STV_MAX));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         owner_q   <= OWN_IF;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         cnt_q     <= '0;
         starve_q  <= '0;
         ifRdata_q <= '0;
         dmRdata_q <= '0;
         ifAck_q   <= 1'b0;
         dmAck_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         cnt_q     <= cnt_d;
         starve_q  <= starve_d;
         ifRdata_q <= ifRdata_d;
         dmRdata_q <= dmRdata_d;
         ifAck_q   <= ifAck_d;
         dmAck_q   <= dmAck_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      cnt_d     = cnt_q;
      ifRdata_d = ifRdata_q;
      dmRdata_d = dmRdata_q;
      ifAck_d   = 1'b0;
      dmAck_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               state_d = ACCESS;
               cnt_d   = CNT_INIT;
               if (grantIf) begin
                  owner_d = OWN_IF;
                  addr_d  = if_addr;
                  wdata_d = '0;
                  we_d    = 1'b0;
               end else begin
                  owner_d = OWN_DM;
                  addr_d  = dm_addr;
                  wdata_d = dm_wdata;
                  we_d    = dm_we;
               end
            end
         end
         ACCESS: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = RESP;
               if (owner_q == OWN_IF) begin
                  ifAck_d = 1'b1;
                  if (!we_q) ifRdata_d = mem_rdata;
               end else begin
                  dmAck_d = 1'b1;
                  if (!we_q) dmRdata_d = mem_rdata;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Starvation counts DM grants taken while IF waits; any cycle without if_req clears it.
   always_comb begin
      starve_d = starve_q;
      if (!if_req) begin
         starve_d = '0;
      end else if (state_q == IDLE) begin
         if (grantIf) begin
            starve_d = '0;
         end else if (starve_q != STV_MAX) begin
            starve_d = starve_q + 1'b1;
         end
      end
   end

   assign inAccess  = (state_q == ACCESS);
   assign mem_en    = inAccess;
   assign mem_we    = inAccess & we_q & (owner_q == OWN_DM);
   assign mem_addr  = inAccess ? addr_q  : '0;
   assign mem_wdata = inAccess ? wdata_q : '0;

   assign if_rdata  = ifRdata_q;
   assign dm_rdata  = dmRdata_q;
   assign if_ack    = ifAck_q;
   assign dm_ack    = dmAck_q;
   assign stall_if  = if_req & ~ifAck_q;
   assign stall_mem = dm_req & ~dmAck_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-timing reference model.
module tb_mem_port_arbiter;

   localparam int L    = 2;
   localparam int SMAX = 4;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        stall_if;
   logic        stall_mem;
   logic        busy;

   int cmpCount = 0;
   int errCount = 0;

   // Reference model: one transaction at a time, timed relative to the cycle it was granted.
   int          cyc;
   int          grantCycle;
   bit          gIsIf;
   bit          gWe;
   logic [31:0] gAddr;
   logic [31:0] gWdata;
   logic [31:0] mIfRdata;
   logic [31:0] mDmRdata;
   int          mStarve;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void modelReset();
      grantCycle = -100;
      gIsIf      = 1'b1;
      gWe        = 1'b0;
      gAddr      = '0;
      gWdata     = '0;
      mIfRdata   = '0;
      mDmRdata   = '0;
      mStarve    = 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmpCount++;
      assert (obs === exp) else begin
         errCount++;
         $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic applyStimulus(input bit ifR, input logic [31:0] ifA, input bit dmR,
                                input bit dmW, input logic [31:0] dmA, input logic [31:0] dmWd,
                                input logic [31:0] mrd);
      if_req    = ifR;
      if_addr   = ifA;
      dm_req    = dmR;
      dm_we     = dmW;
      dm_addr   = dmA;
      dm_wdata  = dmWd;
      mem_rdata = mrd;
   endtask

   task automatic checkOutput();
      int rel;
      bit inAcc, inAck;
      rel   = cyc - grantCycle;
      inAcc = (rel >= 1) && (rel <= L);
      inAck = (rel == L + 1);
      check("mem_en",    32'(mem_en),    32'(inAcc));
      check("mem_we",    32'(mem_we),    32'(inAcc && gWe));
      check("mem_addr",  mem_addr,       inAcc ? gAddr  : 32'h0);
      check("mem_wdata", mem_wdata,      inAcc ? gWdata : 32'h0);
      check("if_ack",    32'(if_ack),    32'(inAck && gIsIf));
      check("dm_ack",    32'(dm_ack),    32'(inAck && !gIsIf));
      check("if_rdata",  if_rdata,       mIfRdata);
      check("dm_rdata",  dm_rdata,       mDmRdata);
      check("stall_if",  32'(stall_if),  32'(if_req && !(inAck && gIsIf)));
      check("stall_mem", 32'(stall_mem), 32'(dm_req && !(inAck && !gIsIf)));
      check("busy",      32'(busy),      32'((rel >= 1) && (rel <= L + 1)));
   endtask

   // Advances the model over a clock edge using the inputs the DUT just sampled.
   task automatic modelEdge();
      int rel;
      bit ifWins;
      if (!rst_n) begin
         modelReset();
      end else begin
         rel = cyc - grantCycle;
         if (rel == L && !gWe) begin
            if (gIsIf) mIfRdata = mem_rdata;
            else       mDmRdata = mem_rdata;
         end
         if (rel >= L + 2 && (if_req || dm_req)) begin
            ifWins     = if_req && (!dm_req || mStarve == SMAX);
            grantCycle = cyc;
            gIsIf      = ifWins;
            gAddr      = ifWins ? if_addr : dm_addr;
            gWe        = !ifWins && dm_we;
            gWdata     = ifWins ? 32'h0 : dm_wdata;
            if (if_req) mStarve = ifWins ? 0 : ((mStarve < SMAX) ? mStarve + 1 : SMAX);
         end
         if (!if_req) mStarve = 0;
      end
      cyc++;
   endtask

   task automatic step();
      #1;
      checkOutput();
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   initial begin
      cyc   = 0;
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkOutput();
      rst_n = 1'b1;

      $display("[TB] fetch");
      applyStimulus(1, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF);
      repeat (3) step();
      check("t1_if_ack", 32'(if_ack), 32'h1);
      check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
      applyStimulus(0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
      repeat (2) step();

      $display("[TB] collision");
      applyStimulus(1, 32'h30, 1, 0, 32'h40, 0, 32'h1111);
      step();
      check("t2_first_addr", mem_addr, 32'h40);
      applyStimulus(1, 32'h30, 0, 0, 0, 0, 32'h1111);
      repeat (2) step();
      check("t2_dm_ack", 32'(dm_ack), 32'h1);
      check("t2_dm_rdata", dm_rdata, 32'h1111);
      mem_rdata = 32'h2222;
      repeat (4) step();
      check("t2_if_ack", 32'(if_ack), 32'h1);
      check("t2_if_rdata", if_rdata, 32'h2222);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (2) step();

      $display("[TB] store");
      applyStimulus(0, 0, 1, 1, 32'h20, 32'h5, 32'hABCD);
      step();
      check("t3_mem_we", 32'(mem_we), 32'h1);
      check("t3_mem_wdata", mem_wdata, 32'h5);
      dm_req = 1'b0;
      repeat (2) step();
      check("t3_dm_ack", 32'(dm_ack), 32'h1);
      check("t3_dm_rdata_kept", dm_rdata, 32'h1111);
      repeat (2) step();

      $display("[TB] starvation");
      applyStimulus(1, 32'h100, 1, 0, 32'h200, 0, 32'h3333);
      for (int k = 0; k < 6; k++) begin
         step();
         check("t4_grant_addr", mem_addr, (k == 4) ? 32'h100 : 32'h200);
         repeat (3) step();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      repeat (2) step();

      $display("[TB] reset during access");
      applyStimulus(0, 0, 1, 0, 32'h44, 0, 32'h9);
      step();
      rst_n = 1'b0;
      #1;
      check("t5_mem_en", 32'(mem_en), 32'h0);
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_dm_ack", 32'(dm_ack), 32'h0);
      modelReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h9);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (4) step();

      $display("[TB] drop after grant");
      applyStimulus(0, 0, 1, 0, 32'h8, 0, 32'h77);
      step();
      applyStimulus(0, 0, 0, 0, 0, 0, 32'h77);
      repeat (2) step();
      check("t6_dm_ack", 32'(dm_ack), 32'h1);
      check("t6_dm_rdata", dm_rdata, 32'h77);
      repeat (2) step();

      $display("[TB] random traffic");
      for (int n = 0; n < 500; n++) begin
         applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                       $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
